// File: rtl/comparator_pkg.sv
// Shared definitions for the comparator sweep driver and anything that checks
// the 2-bit (or WIDTH-bit) equality comparator.
//   state_t    : sweep FSM states
//   MAX_WIDTH  : widest operand golden_eq accepts (callers zero-extend)
//   num_pairs  : number of (A,B) operand pairs for a given operand width
//   golden_eq  : reference result of the comparator (S=1 iff A==B)
package comparator_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DRIVE  = 2'd1,
    SAMPLE = 2'd2,
    DONE   = 2'd3
  } state_t;

  localparam int MAX_WIDTH = 16;

  // 4**width, written as a shift so it stays an integer constant function.
  function automatic int num_pairs(input int width);
    return 1 << (2 * width);
  endfunction

  function automatic logic golden_eq(input logic [MAX_WIDTH-1:0] a,
                                     input logic [MAX_WIDTH-1:0] b);
    return a == b;
  endfunction

endpackage

// File: rtl/sweep_index_gen.sv
// Operand-pair index and settle counter for the sweep.
//   clear       : index and settle counter back to 0 (start of a sweep)
//   tick        : advance the settle counter (pair is being held)
//   step        : advance to the next pair and restart the settle counter
//   index       : {A,B} operand pair currently driven
//   settle_done : settle counter has reached SETTLE-1 (pair held long enough)
//   last        : index is the final pair (all ones)
// Priority is clear > step > tick; the FSM never asserts two at once.
module sweep_index_gen
  import comparator_pkg::*;
#(
  parameter int WIDTH  = 2,
  parameter int SETTLE = 1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               clear,
  input  logic               tick,
  input  logic               step,
  output logic [2*WIDTH-1:0] index,
  output logic               settle_done,
  output logic               last
);

  localparam int IW        = 2 * WIDTH;
  localparam int SW        = (SETTLE > 1) ? $clog2(SETTLE) : 1;
  localparam int NUM_PAIRS = num_pairs(WIDTH);

  logic [SW-1:0] settle;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      index  <= '0;
      settle <= '0;
    end else if (clear) begin
      index  <= '0;
      settle <= '0;
    end else if (step) begin
      index  <= index + IW'(1);
      settle <= '0;
    end else if (tick) begin
      settle <= settle + SW'(1);
    end
  end

  assign settle_done = (settle == SW'(SETTLE - 1));
  assign last        = (index == IW'(NUM_PAIRS - 1));

endmodule

// File: rtl/comparator_sweep_driver.sv
// Self-checking stimulus driver for the equality comparator. On start it
// walks every (A,B) pair, holds each for SETTLE cycles, samples s_in on the
// following cycle and compares it with the golden equality result.
//   clk, rst_n        : clock (rising edge), async active-low reset
//   start             : begin a sweep; acted on only in IDLE or DONE
//   s_in              : comparator output under test
//   a_out, b_out      : operands driven to the comparator (registered)
//   busy              : sweep in progress (DRIVE or SAMPLE)
//   done              : sweep finished, held until next start or reset
//   pass              : done with zero mismatches
//   err_count         : number of mismatching pairs
//   err_valid         : at least one mismatch captured
//   first_err_a/b     : operands of the first mismatching pair
//   state_dbg         : current FSM state
// start is a level sampled on the clock: it is accepted on any edge where the
// FSM is in IDLE or DONE and ignored while busy; there is no ready/ack.
module comparator_sweep_driver
  import comparator_pkg::*;
#(
  parameter int WIDTH  = 2,
  parameter int SETTLE = 1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic               s_in,
  output logic [WIDTH-1:0]   a_out,
  output logic [WIDTH-1:0]   b_out,
  output logic               busy,
  output logic               done,
  output logic               pass,
  output logic [2*WIDTH:0]   err_count,
  output logic               err_valid,
  output logic [WIDTH-1:0]   first_err_a,
  output logic [WIDTH-1:0]   first_err_b,
  output logic [1:0]         state_dbg
);

  localparam int IW = 2 * WIDTH;
  localparam int EW = 2 * WIDTH + 1;

  state_t          state, state_nxt;
  logic            clear, tick, step;
  logic [IW-1:0]   index;
  logic            settle_done, last;
  logic            expected, mismatch;

  sweep_index_gen #(
    .WIDTH  (WIDTH),
    .SETTLE (SETTLE)
  ) u_index (
    .clk         (clk),
    .rst_n       (rst_n),
    .clear       (clear),
    .tick        (tick),
    .step        (step),
    .index       (index),
    .settle_done (settle_done),
    .last        (last)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    clear     = 1'b0;
    tick      = 1'b0;
    step      = 1'b0;
    case (state)
      IDLE, DONE: begin
        if (start) begin
          clear     = 1'b1;
          state_nxt = DRIVE;
        end
      end
      DRIVE: begin
        if (settle_done) state_nxt = SAMPLE;
        else             tick      = 1'b1;
      end
      SAMPLE: begin
        if (last) begin
          state_nxt = DONE;
        end else begin
          step      = 1'b1;
          state_nxt = DRIVE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign a_out = index[IW-1:WIDTH];
  assign b_out = index[WIDTH-1:0];

  assign expected = golden_eq(MAX_WIDTH'(a_out), MAX_WIDTH'(b_out));
  // s_in is only meaningful in SAMPLE; everywhere else it is ignored.
  assign mismatch = (state == SAMPLE) && (s_in != expected);

  // Results are cleared on the same edge that accepts start, so a restart
  // from DONE never shows stale results once busy rises.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_count   <= '0;
      err_valid   <= 1'b0;
      first_err_a <= '0;
      first_err_b <= '0;
    end else if (clear) begin
      err_count   <= '0;
      err_valid   <= 1'b0;
      first_err_a <= '0;
      first_err_b <= '0;
    end else if (mismatch) begin
      // Width 2W+1 holds 4**W, so every pair failing cannot wrap.
      err_count <= err_count + EW'(1);
      if (!err_valid) begin
        err_valid   <= 1'b1;
        first_err_a <= a_out;
        first_err_b <= b_out;
      end
    end
  end

  assign busy      = (state == DRIVE) || (state == SAMPLE);
  assign done      = (state == DONE);
  assign pass      = done && (err_count == '0);
  assign state_dbg = state;

endmodule

// File: tb/tb_comparator_sweep_driver.sv
module tb_comparator_sweep_driver;
  import comparator_pkg::*;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  // ---------------- DUT signals ----------------
  logic       start1, s_in1, busy1, done1, pass1, err_valid1;
  logic [1:0] a1, b1, fa1, fb1, st1;
  logic [4:0] err_count1;
  logic       start3, s_in3, busy3, done3, pass3, err_valid3;
  logic [1:0] a3, b3, fa3, fb3, st3;
  logic [4:0] err_count3;

  int mode1 = 0;
  int mode3 = 0;

  // Comparator stand-ins: 0 good, 1 stuck at 0, 2 stuck at 1, 3 inverted.
  function automatic logic cmp_model(input int mode, input logic [1:0] a,
                                     input logic [1:0] b);
    case (mode)
      0:       return a == b;
      1:       return 1'b0;
      2:       return 1'b1;
      default: return a != b;
    endcase
  endfunction

  assign s_in1 = cmp_model(mode1, a1, b1);
  assign s_in3 = cmp_model(mode3, a3, b3);

  comparator_sweep_driver #(.WIDTH(2), .SETTLE(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .start(start1), .s_in(s_in1),
    .a_out(a1), .b_out(b1), .busy(busy1), .done(done1), .pass(pass1),
    .err_count(err_count1), .err_valid(err_valid1),
    .first_err_a(fa1), .first_err_b(fb1), .state_dbg(st1)
  );

  comparator_sweep_driver #(.WIDTH(2), .SETTLE(3)) dut3 (
    .clk(clk), .rst_n(rst_n), .start(start3), .s_in(s_in3),
    .a_out(a3), .b_out(b3), .busy(busy3), .done(done3), .pass(pass3),
    .err_count(err_count3), .err_valid(err_valid3),
    .first_err_a(fa3), .first_err_b(fb3), .state_dbg(st3)
  );

  // ---------------- scoreboard ----------------
  int tests = 0;
  int fails = 0;
  logic [3:0] exp_q[$];
  bit mon_en = 1'b0;

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Every SAMPLE cycle of dut1 must present the next expected pair.
  always @(negedge clk) begin
    if (mon_en && st1 == SAMPLE) begin
      logic [3:0] e;
      e = 'x;
      if (exp_q.size() != 0) e = exp_q.pop_front();
      check("sweep_order", {28'd0, a1, b1}, {28'd0, e});
    end
  end

  // ---------------- driver tasks ----------------
  // Returns at the negedge right after the edge that accepted start (cycle 0).
  task automatic pulse_start1();
    @(negedge clk); start1 = 1'b1;
    @(negedge clk); start1 = 1'b0;
  endtask

  task automatic pulse_start3();
    @(negedge clk); start3 = 1'b1;
    @(negedge clk); start3 = 1'b0;
  endtask

  task automatic wait_done(input int which, input int cyc0, output int cyc);
    cyc = cyc0;
    while (((which == 1) ? !done1 : !done3) && cyc < 300) begin
      @(negedge clk);
      cyc++;
    end
  endtask

  task automatic check_dut1_zero(input string tag);
    check(tag, {15'd0, a1, b1, busy1, done1, pass1, err_count1, err_valid1,
                fa1, fb1}, 32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  // ---------------- stimulus ----------------
  initial begin
    int cyc;
    int cnt;
    rst_n  = 1'b0;
    start1 = 1'b0;
    start3 = 1'b0;
    repeat (2) @(negedge clk);
    check_dut1_zero("reset_outputs");
    check("reset_state", {30'd0, st1}, {30'd0, IDLE});
    check("reset_dut3", {15'd0, a3, b3, busy3, done3, pass3, err_count3,
                         err_valid3, fa3, fb3}, 32'd0);
    rst_n = 1'b1;

    // 1: good comparator, full ordered sweep
    for (int i = 0; i < 16; i++) exp_q.push_back(i[3:0]);
    mon_en = 1'b1;
    mode1  = 0;
    pulse_start1();
    wait_done(1, 0, cyc);
    mon_en = 1'b0;
    check("t1_done_cycle", cyc, 32);
    check("t1_all_pairs_seen", exp_q.size(), 0);
    check("t1_pass", pass1, 1);
    check("t1_err_count", err_count1, 0);
    check("t1_err_valid", err_valid1, 0);
    check("t1_last_pair", {a1, b1}, 4'hF);
    check("t1_busy", busy1, 0);

    // 2: stuck at 0 -> fails the four equal pairs
    mode1 = 1;
    pulse_start1();
    wait_done(1, 0, cyc);
    check("t2_done_cycle", cyc, 32);
    check("t2_err_count", err_count1, 4);
    check("t2_first_err", {fa1, fb1}, 4'h0);
    check("t2_err_valid", err_valid1, 1);
    check("t2_pass", pass1, 0);

    // 3: stuck at 1 -> fails the twelve unequal pairs, first is (0,1)
    mode1 = 2;
    pulse_start1();
    wait_done(1, 0, cyc);
    check("t3_err_count", err_count1, 12);
    check("t3_first_err", {fa1, fb1}, 4'h1);
    check("t3_pass", pass1, 0);

    // 4: inverted -> all sixteen fail, count does not wrap
    mode1 = 3;
    pulse_start1();
    wait_done(1, 0, cyc);
    check("t4_err_count", err_count1, 16);
    check("t4_err_valid", err_valid1, 1);
    check("t4_first_err", {fa1, fb1}, 4'h0);
    check("t4_pass", pass1, 0);

    // 5a: start while busy is ignored
    mode1 = 0;
    pulse_start1();
    repeat (10) @(negedge clk);
    start1 = 1'b1;
    @(negedge clk);
    start1 = 1'b0;
    check("t5_still_busy", busy1, 1);
    check("t5_index_kept", {a1, b1}, 4'h5);
    wait_done(1, 11, cyc);
    check("t5_done_cycle", cyc, 32);
    check("t5_pass", pass1, 1);

    // 5b: reset in the middle of a failing sweep
    mode1 = 3;
    pulse_start1();
    cnt = 0;
    while ({a1, b1} != 4'h5 && cnt < 40) begin
      @(negedge clk);
      cnt++;
    end
    check("t5_reach_idx5", {a1, b1}, 4'h5);
    check("t5_errs_before_rst", err_count1, 5);
    rst_n = 1'b0;
    #1;
    check_dut1_zero("t5_async_reset");
    check("t5_reset_state", {30'd0, st1}, {30'd0, IDLE});
    @(negedge clk);
    rst_n = 1'b1;
    mode1 = 0;
    pulse_start1();
    check("t5_restart_index", {a1, b1}, 4'h0);
    wait_done(1, 0, cyc);
    check("t5_resweep_cycle", cyc, 32);
    check("t5_resweep_pass", pass1, 1);
    check("t5_resweep_errs", err_count1, 0);

    // 6a: SETTLE=3, each pair held 3 DRIVE cycles then sampled
    mode3 = 0;
    pulse_start3();
    check("t6_c0_state", {30'd0, st3}, {30'd0, DRIVE});
    check("t6_c0_pair", {a3, b3}, 4'h0);
    @(negedge clk);
    check("t6_c1_state", {30'd0, st3}, {30'd0, DRIVE});
    @(negedge clk);
    check("t6_c2_state", {30'd0, st3}, {30'd0, DRIVE});
    check("t6_c2_pair", {a3, b3}, 4'h0);
    @(negedge clk);
    check("t6_c3_state", {30'd0, st3}, {30'd0, SAMPLE});
    @(negedge clk);
    check("t6_c4_state", {30'd0, st3}, {30'd0, DRIVE});
    check("t6_c4_pair", {a3, b3}, 4'h1);
    wait_done(3, 4, cyc);
    check("t6_done_cycle", cyc, 64);
    check("t6_pass", pass3, 1);

    // 6b: failing run, then start from DONE clears on the next edge
    mode3 = 1;
    pulse_start3();
    wait_done(3, 0, cyc);
    check("t6_stuck0_errs", err_count3, 4);
    check("t6_stuck0_pass", pass3, 0);
    mode3 = 0;
    pulse_start3();
    check("t6_restart_done", done3, 0);
    check("t6_restart_busy", busy3, 1);
    check("t6_restart_errs", err_count3, 0);
    check("t6_restart_valid", err_valid3, 0);
    wait_done(3, 0, cyc);
    check("t6_rerun_cycle", cyc, 64);
    check("t6_rerun_pass", pass3, 1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/comparator_sweep_driver.md
Name: comparator_sweep_driver

Overview:
Self-checking stimulus driver that sits on the opposite side of the team's 2-bit equality comparator (S=1 iff A==B). On start it drives every (A,B) operand pair onto the comparator inputs in a fixed order. It samples the comparator's S output and checks it against a golden equality result. It reports pass/fail, a mismatch count and the first failing pair, and is used for board bring-up and as a BIST wrapper.

Parameters:
WIDTH, 2, operand width in bits; the sweep covers 4^WIDTH pairs.
SETTLE, 1, cycles the pair is held before S is sampled (minimum 1).

Ports:
clk  input  1  single clock, rising edge
rst_n  input  1  reset, asynchronous and active-low
start  input  1  begin sweep; honoured only in IDLE or DONE
s_in  input  1  comparator result under test
a_out  output  WIDTH  operand A to comparator
b_out  output  WIDTH  operand B to comparator
busy  output  1  high in DRIVE/SAMPLE
done  output  1  high in DONE, held until next start or reset
pass  output  1  done && err_count==0; 0 otherwise
err_count  output  2*WIDTH+1  number of mismatching pairs
err_valid  output  1  at least one mismatch captured
first_err_a  output  WIDTH  A of first mismatching pair
first_err_b  output  WIDTH  B of first mismatching pair

Behaviour:
- Reset (async assert, sync release): state=IDLE; index, settle counter, err_count, first_err_* = 0; all outputs 0.
- index is 2*WIDTH bits: a_out=index[2W-1:W], b_out=index[W-1:0]. Outputs are registered and change only on index update.
- States: IDLE, DRIVE, SAMPLE, DONE.
- IDLE: start=1 -> DRIVE; index=0, err_count=0, err_valid=0, first_err_*=0, settle=0.
- DRIVE: settle++ each cycle. On reaching SETTLE-1 -> SAMPLE.
- SAMPLE: one cycle. expected=(a_out==b_out).
  - If s_in!=expected: err_count++. If err_valid was 0, capture first_err_a/b and set err_valid.
  - If index==all-ones -> DONE; else index++, settle=0 -> DRIVE.
- DONE: done=1, pass=(err_count==0). a_out/b_out hold the last pair. start=1 -> restart exactly as from IDLE (clears results in the same edge).
- Per pair: SETTLE+1 cycles. done rises 4^WIDTH*(SETTLE+1) cycles after the edge that samples start (WIDTH=2, SETTLE=1: 32 cycles).
- start while busy is ignored; the sweep is not restarted.
- s_in is sampled only in SAMPLE; its value elsewhere is don't-care.
- err_count cannot overflow: the width holds 4^WIDTH. No saturation logic.
- rst_n asserted mid-sweep forces IDLE immediately, all results cleared. A later start runs a complete sweep from index 0.
- start and last SAMPLE cannot coincide, because start is ignored while busy.

Decomposition:
- Shared package comparator_pkg:
  - state enum (IDLE, DRIVE, SAMPLE, DONE);
  - localparam NUM_PAIRS = 4**WIDTH as a function of width;
  - function golden_eq(a,b) returning a==b, reused by the bench scoreboard.
- One natural sub-module, sweep_index_gen: index register, settle counter and last-pair flag, with step/clear inputs.
- The FSM and error capture stay in the top.

Test Plan:
1. Correct comparator model on s_in, WIDTH=2, SETTLE=1, pulse start -> done at cycle 32, pass=1, err_count=0, err_valid=0, a_out/b_out sweep 0/0..3/3 in order.
2. s_in stuck at 0 -> err_count=4, first_err_a=0, first_err_b=0, pass=0.
3. s_in stuck at 1 -> err_count=12, first_err_a=0, first_err_b=1, pass=0.
4. s_in inverted comparator -> err_count=16 (no overflow), err_valid=1, pass=0.
5. start re-pulsed at cycle 10 -> ignored, done still at cycle 32. rst_n low at pair index 5 -> all outputs 0 immediately. New start gives a full 32-cycle sweep with pass=1.
6. SETTLE=3, correct model -> each pair held 3 cycles, sampled on the 4th, done at cycle 64, pass=1. Start in DONE restarts and clears done next cycle.
